aes_round_ctrl: RTL and testbench

Round sequencer for the AES-128 encryption core. It steps the shared combinational round datapath (sub_bytes, shift_rows, mix_columns, add_round_key) through the initial key addition, the main rounds and the final round. Before each round it fetches the round key from the key-expansion block over a req/ack handshake. It drives the per-stage enables and the state-register write strobe; the 128-bit state register and the datapath itself sit outside this block.

---
 rtl/aes_round_ctrl.sv | 93 +++++++++
 tb/tb_aes_round_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 core: walks the shared round datapath through
// the initial key addition, the main rounds and the final round, fetching each round key first.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_ack,
    output logic       busy,
    output logic       done,
    output logic       key_req,
    output logic [3:0] key_round,
    output logic [3:0] round_num,
    output logic       sel_input,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       state_we
);

    typedef enum logic [1:0] {IDLE, KEY_WAIT, APPLY, DONE} state_t;

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    state_t     state, stateNext;
    logic [3:0] roundNext;
    logic       applyNext;

    always_comb begin
        stateNext = state;
        roundNext = round_num;
        case (state)
            IDLE: begin
                roundNext = 4'd0;
                if (start) stateNext = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (key_ack) stateNext = APPLY;
            end
            APPLY: begin
                if (round_num == LastRound) begin
                    stateNext = DONE;
                end else begin
                    stateNext = KEY_WAIT;
                    roundNext = round_num + 4'd1;
                end
            end
            DONE: begin
                stateNext = IDLE;
                roundNext = 4'd0;
            end
            default: begin
                stateNext = IDLE;
                roundNext = 4'd0;
            end
        endcase
    end

    assign applyNext = (stateNext == APPLY);
    assign key_round = round_num;

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_num <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_req   <= 1'b0;
            sel_input <= 1'b0;
            sub_en    <= 1'b0;
            shift_en  <= 1'b0;
            mix_en    <= 1'b0;
            ark_en    <= 1'b0;
            state_we  <= 1'b0;
        end else begin
            state     <= stateNext;
            round_num <= roundNext;
            busy      <= (stateNext == KEY_WAIT) || applyNext;
            done      <= (stateNext == DONE);
            key_req   <= (stateNext == KEY_WAIT);
            sel_input <= applyNext && (roundNext == 4'd0);
            sub_en    <= applyNext && (roundNext != 4'd0);
            shift_en  <= applyNext && (roundNext != 4'd0);
            mix_en    <= applyNext && (roundNext != 4'd0) && (roundNext != LastRound);
            ark_en    <= applyNext;
            state_we  <= applyNext;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: expected per-round strobe events are queued
// when a run is launched and popped by an independent monitor.
module tb_aes_round_ctrl;

    localparam int N  = 10;
    localparam int N2 = 14;

    logic       clk = 1'b0;
    logic       rst, start, key_ack;
    logic       busy, done, key_req, sel_input, sub_en, shift_en, mix_en, ark_en, state_we;
    logic [3:0] key_round, round_num;

    logic       start14, ack14;
    logic       busy14, done14, keyReq14, sel14, sub14, shift14, mix14, ark14, we14;
    logic [3:0] keyRound14, round14;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       isDone;
        logic [3:0] rnd;
        logic       sel, sub, shift, mix, ark;
    } ev_t;

    ev_t expQ[$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .key_ack(key_ack),
        .busy(busy), .done(done), .key_req(key_req), .key_round(key_round),
        .round_num(round_num), .sel_input(sel_input), .sub_en(sub_en),
        .shift_en(shift_en), .mix_en(mix_en), .ark_en(ark_en), .state_we(state_we)
    );

    aes_round_ctrl #(.NUM_ROUNDS(N2)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .key_ack(ack14),
        .busy(busy14), .done(done14), .key_req(keyReq14), .key_round(keyRound14),
        .round_num(round14), .sel_input(sel14), .sub_en(sub14),
        .shift_en(shift14), .mix_en(mix14), .ark_en(ark14), .state_we(we14)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One run = initial key addition, N-1 full rounds, final round without MixColumns, then done.
    function automatic void pushRun(input int n);
        ev_t e;
        for (int r = 0; r <= n; r++) begin
            e.isDone = 1'b0;
            e.rnd    = 4'(r);
            e.sel    = (r == 0);
            e.sub    = (r > 0);
            e.shift  = (r > 0);
            e.mix    = (r > 0) && (r < n);
            e.ark    = 1'b1;
            expQ.push_back(e);
        end
        e = '0;
        e.isDone = 1'b1;
        e.rnd    = 4'(n);
        expQ.push_back(e);
    endfunction

    function automatic logic [18:0] allOut();
        return {busy, done, key_req, key_round, round_num, sel_input, sub_en,
                shift_en, mix_en, ark_en, state_we};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            ev_t act;
            act = {done, round_num, sel_input, sub_en, shift_en, mix_en, ark_en};
            if (state_we || done) begin
                if (expQ.size() == 0) begin
                    check("unexpected_event", 32'(act), 32'h0);
                end else begin
                    ev_t e;
                    e = expQ.pop_front();
                    check("event", 32'(act), 32'(e));
                end
            end else begin
                check("strobes_idle", {27'd0, sel_input, sub_en, shift_en, mix_en, ark_en}, 32'd0);
            end
            check("key_round_eq", 32'(key_round), 32'(round_num));
            if (round_num > 4'(N)) check("round_bound", 32'(round_num), 32'(N));
        end
    end

    task automatic runOne(input int stallRound, input int stallLen, input bit poke);
        int  busyCnt, stall, cyc;
        bit  doneSeen, prevHeld;
        pushRun(N);
        @(negedge clk);
        start   = 1'b1;
        key_ack = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busyCnt  = 0;
        stall    = 0;
        cyc      = 0;
        doneSeen = 1'b0;
        prevHeld = 1'b0;
        while (!doneSeen && cyc < 200) begin
            if (busy) busyCnt++;
            if (done) doneSeen = 1'b1;
            if (prevHeld)
                check("stall_hold", {26'd0, key_req, state_we, round_num}, {26'd0, 1'b1, 1'b0, 4'(stallRound)});
            prevHeld = 1'b0;
            if (key_req && round_num == 4'(stallRound) && stall < stallLen) begin
                key_ack  = 1'b0;
                stall++;
                prevHeld = 1'b1;
            end else begin
                key_ack = 1'b1;
            end
            start = poke && ((round_num == 4'd4 && state_we) || done);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(doneSeen), 32'd1);
        check("busy_cycles", 32'(busyCnt), 32'(2 * (N + 1) + stallLen));
        check("idle_after", {30'd0, busy, key_req}, 32'd0);
        repeat (3) @(negedge clk);
        check("idle_stays", 32'(busy), 32'd0);
        check("queue_empty", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int rise[2];
        int rises, cnt, mixCnt, busyCnt;
        bit prevBusy, sawDone;

        rst = 1'b1; start = 1'b1; key_ack = 1'b1; start14 = 1'b1; ack14 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 32'(allOut()), 32'd0);
            check("reset_outputs14", {31'd0, busy14}, 32'd0);
        end
        start = 1'b0; start14 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(allOut()), 32'd0);

        runOne(-1, 0, 1'b0);
        runOne(5, 3, 1'b0);
        runOne(-1, 0, 1'b1);
        runOne(3, $urandom_range(1, 6) - 1, 1'b0);

        // Start held high: back-to-back runs.
        pushRun(N);
        pushRun(N);
        @(negedge clk);
        start = 1'b1; key_ack = 1'b1;
        rises = 0; cnt = 0; prevBusy = busy;
        while (rises < 2 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (busy && !prevBusy) begin
                rise[rises] = cnt;
                rises++;
            end
            prevBusy = busy;
        end
        start = 1'b0;
        check("b2b_rises", 32'(rises), 32'd2);
        check("b2b_gap", 32'(rise[1] - rise[0]), 32'(2 * (N + 1) + 2));
        cnt = 0;
        while (expQ.size() > 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        check("b2b_queue_empty", 32'(expQ.size()), 32'd0);

        // Asynchronous reset in the middle of round 4's APPLY cycle.
        pushRun(N);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(state_we && round_num == 4'd4) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("reached_round4", 32'(round_num), 32'd4);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", 32'(allOut()), 32'd0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_done_after_reset", {31'd0, busy}, 32'd0);
        runOne(-1, 0, 1'b0);

        // NUM_ROUNDS=14 instance.
        @(negedge clk);
        start14 = 1'b1;
        @(negedge clk);
        start14 = 1'b0;
        busyCnt = 0; mixCnt = 0; sawDone = 1'b0; cnt = 0;
        while (!sawDone && cnt < 200) begin
            if (busy14) busyCnt++;
            if (mix14) mixCnt++;
            if (done14) begin
                sawDone = 1'b1;
                check("p14_done_round", 32'(round14), 32'(N2));
            end
            cnt++;
            @(negedge clk);
        end
        check("p14_done_seen", 32'(sawDone), 32'd1);
        check("p14_busy", 32'(busyCnt), 32'(2 * (N2 + 1)));
        check("p14_mix", 32'(mixCnt), 32'(N2 - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
